// File: rtl/pipe_arith_hs.sv
// pipe_arith_hs: three-stage arithmetic pipeline with valid/ready handshakes.
//   Stage 1: x1 = A + B, x2 = C - D; D and mode registered alongside.
//   Stage 2: x3 = x1 + x2; D and mode carried forward.
//   Stage 3: F = x3*D | x3+D | x3-D | x3, selected by mode.
// All arithmetic is unsigned modulo 2^N.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   A,B,C,D    N-bit unsigned operands
//   mode       2-bit final-stage operation select, captured with the operands
//   in_valid   operand set valid
//   in_ready   stage 1 accepts an operand set this cycle (combinational)
//   F          stage-3 result
//   out_valid  F holds a valid result (stage-3 valid bit)
//   out_ready  consumer accepts F this cycle
//   occ        number of valid stages (0..3)
module pipe_arith_hs #(
    parameter int unsigned N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] F,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occ
);

    localparam int unsigned MW = 2;

    typedef enum logic [MW-1:0] {
        MODE_MUL = 2'b00,
        MODE_ADD = 2'b01,
        MODE_SUB = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    // Stage valid bits (stage 3 valid is out_valid)
    logic v1;
    logic v2;

    // Stage 1 data
    logic [N-1:0]  x1_q;
    logic [N-1:0]  x2_q;
    logic [N-1:0]  d1_q;
    logic [MW-1:0] m1_q;

    // Stage 2 data
    logic [N-1:0]  x3_q;
    logic [N-1:0]  d2_q;
    logic [MW-1:0] m2_q;

    // Handshake / load enables
    logic ld1;
    logic ld2;
    logic ld3;
    logic in_xfer;
    logic out_xfer;

    logic [N-1:0] f_next;

    // A stage may load when empty or when it is itself moving on this cycle.
    // The chain runs back from the consumer so bubbles get squeezed out.
    always_comb begin
        ld3      = !out_valid || out_ready;
        ld2      = !v2 || ld3;
        ld1      = !v1 || ld2;
        // Hold off acceptance while reset is applied so nothing transfers.
        in_ready = ld1 && !rst;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
    end

    // Final-stage operation on stage-2 contents
    always_comb begin
        f_next = x3_q;
        case (mode_e'(m2_q))
            MODE_MUL:  f_next = x3_q * d2_q;
            MODE_ADD:  f_next = x3_q + d2_q;
            MODE_SUB:  f_next = x3_q - d2_q;
            MODE_PASS: f_next = x3_q;
            default:   f_next = x3_q;
        endcase
    end

    // Valid bits and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (ld1) begin
                v1 <= in_xfer;
            end
            if (ld2) begin
                v2 <= v1;
            end
            if (ld3) begin
                out_valid <= v2;
            end
            occ <= occ + 2'(in_xfer) - 2'(out_xfer);
        end
    end

    // Stage 1 data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            d1_q <= '0;
            m1_q <= '0;
        end else if (in_xfer) begin
            x1_q <= A + B;
            x2_q <= C - D;
            d1_q <= D;
            m1_q <= mode;
        end
    end

    // Stage 2 data capture, only from a valid stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x3_q <= '0;
            d2_q <= '0;
            m2_q <= '0;
        end else if (ld2 && v1) begin
            x3_q <= x1_q + x2_q;
            d2_q <= d1_q;
            m2_q <= m1_q;
        end
    end

    // Stage 3 result; loading only valid data keeps F at 0 until the first
    // real result and holds it steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F <= '0;
        end else if (ld3 && v2) begin
            F <= f_next;
        end
    end

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Testbench for pipe_arith_hs (N=10): directed scenarios plus a random
// stream checked against a reference queue.
module tb_pipe_arith_hs;

    localparam int unsigned N = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] F;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   occ;

    int checks = 0;
    int errors = 0;

    pipe_arith_hs #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .F        (F),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result of one operand set, modulo 2^N
    function automatic logic [N-1:0] ref_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d,
                                           input logic [1:0] m);
        logic [N-1:0] x1, x2, x3, r;
        x1 = a + b;
        x2 = c - d;
        x3 = x1 + x2;
        case (m)
            2'b00:   r = x3 * d;
            2'b01:   r = x3 + d;
            2'b10:   r = x3 - d;
            default: r = x3;
        endcase
        return r;
    endfunction

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input int c, input int d, input int m);
        A    = N'(a);
        B    = N'(b);
        C    = N'(c);
        D    = N'(d);
        mode = 2'(m);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        drive(1, 2, 3, 4, 0);
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
        checks++; if (F !== 10'd0) begin errors++; $display("FAIL rst_F got %0d exp 0", F); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        step();
        step();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_hold_occ got %0d exp 0", occ); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(3, 4, 10, 2, 0);
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || F !== 10'd0) begin errors++; $display("FAIL basic_edge1 got v=%0b F=%0d exp v=0 F=0", out_valid, F); end
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL basic_occ1 got %0d exp 1", occ); end
        step();
        checks++; if (out_valid !== 1'b0 || F !== 10'd0) begin errors++; $display("FAIL basic_edge2 got v=%0b F=%0d exp v=0 F=0", out_valid, F); end
        step();
        checks++; if (out_valid !== 1'b1 || F !== 10'd30) begin errors++; $display("FAIL basic_edge3 got v=%0b F=%0d exp v=1 F=30", out_valid, F); end
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL basic_occ3 got %0d exp 1", occ); end
        step();
        checks++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL basic_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid, occ); end
    endtask

    // Wrap/truncate vectors followed by the three non-multiply modes, back to back
    task automatic test_arith();
        int va[5] = '{1023, 500, 3, 3, 3};
        int vb[5] = '{1, 0, 4, 4, 4};
        int vc[5] = '{0, 12, 10, 10, 10};
        int vd[5] = '{1, 12, 2, 2, 2};
        int vm[5] = '{0, 0, 1, 2, 3};
        int ve[5] = '{1023, 880, 17, 13, 15};
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 5) begin
                drive(va[c], vb[c], vc[c], vd[c], vm[c]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            // Set c is accepted at edge c+1 and must be presented after edge c+3
            if (c >= 3 && c < 8) begin
                checks++;
                if (out_valid !== 1'b1 || F !== N'(ve[c-3])) begin
                    errors++;
                    $display("FAIL arith_%0d got v=%0b F=%0d exp v=1 F=%0d", c - 3, out_valid, F, ve[c-3]);
                end
                got++;
            end else if (out_valid === 1'b1) begin
                checks++; errors++;
                $display("FAIL arith_extra cycle %0d got v=1 exp v=0", c);
            end
            step();
        end
        checks++; if (got != 5) begin errors++; $display("FAIL arith_count got %0d exp 5", got); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_q[5];
        logic [N-1:0] f_hold;
        int sent = 0;
        int got = 0;
        logic acc;
        for (int i = 0; i < 5; i++) exp_q[i] = ref_f(N'(i + 1), N'(2 * i), N'(20 + i), N'(i), 2'(i));
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (sent < 5);
            drive(sent + 1, 2 * sent, 20 + sent, sent, sent);
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b1;
        #1;
        checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted got %0d exp 3", sent); end
        checks++; if (occ !== 2'd3) begin errors++; $display("FAIL bp_occ got %0d exp 3", occ); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || F !== exp_q[0]) begin errors++; $display("FAIL bp_head got v=%0b F=%0d exp v=1 F=%0d", out_valid, F, exp_q[0]); end
        f_hold = F;
        step();
        step();
        checks++; if (F !== f_hold || out_valid !== 1'b1 || occ !== 2'd3) begin errors++; $display("FAIL bp_stable got F=%0d v=%0b occ=%0d exp F=%0d v=1 occ=3", F, out_valid, occ, f_hold); end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && got < 5; c++) begin
            in_valid = (sent < 5);
            drive(sent + 1, 2 * sent, 20 + sent, sent, sent);
            #1;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_gap cycle %0d got v=%0b exp v=1", c, out_valid);
            end else if (F !== exp_q[got]) begin
                errors++;
                $display("FAIL bp_order_%0d got F=%0d exp F=%0d", got, F, exp_q[got]);
            end
            if (out_valid === 1'b1) got++;
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++; if (got != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", got); end
        step();
        checks++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL bp_empty got v=%0b occ=%0d exp v=0 occ=0", out_valid, occ); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(3, 4, 10, 2, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b1 || F !== 10'd30) begin errors++; $display("FAIL rm_result got v=%0b F=%0d exp v=1 F=30", out_valid, F); end
        out_ready = 1'b0;
        drive(7, 7, 7, 7, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL rm_occ2 got %0d exp 2", occ); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || occ !== 2'd0 || F !== 10'd0) begin errors++; $display("FAIL rm_async got v=%0b occ=%0d F=%0d exp v=0 occ=0 F=0", out_valid, occ, F); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL rm_stale cycle %0d got v=%0b occ=%0d exp v=0 occ=0", c, out_valid, occ); end
            step();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] q[$];
        logic [N-1:0] e;
        int accepted = 0;
        int occ_m = 0;
        logic ix, ox;
        for (int c = 0; c < 60000 && (accepted < 10000 || q.size() > 0); c++) begin
            in_valid  = (accepted < 10000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            A = N'($urandom); B = N'($urandom); C = N'($urandom); D = N'($urandom);
            mode = 2'($urandom);
            #1;
            ix = in_valid && in_ready;
            ox = out_valid && out_ready;
            checks++;
            if (in_ready !== ((occ_m < 3) || out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready cycle %0d got %0b occ_m %0d out_ready %0b", c, in_ready, occ_m, out_ready);
            end
            if (ox) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious cycle %0d got F=%0d exp no result", c, F);
                end else begin
                    e = q.pop_front();
                    if (F !== e) begin errors++; $display("FAIL rnd_data cycle %0d got F=%0d exp F=%0d", c, F, e); end
                end
            end
            if (ix) begin
                q.push_back(ref_f(A, B, C, D, mode));
                accepted++;
            end
            step();
            occ_m = occ_m + int'(ix) - int'(ox);
            checks++;
            if (occ !== 2'(occ_m)) begin errors++; $display("FAIL rnd_occ cycle %0d got %0d exp %0d", c, occ, occ_m); end
        end
        in_valid = 1'b0;
        checks++; if (accepted != 10000 || q.size() != 0) begin errors++; $display("FAIL rnd_complete got accepted=%0d pending=%0d exp 10000 and 0", accepted, q.size()); end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_arith();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
